// File: rtl/jtag_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jtag_tap_ctrl
// Description : IEEE 1149.1 TAP controller, oversampled in the system clock.
//               TCK/TMS/TDI are synchronised into clk and TCK edges become
//               one-cycle rise/fall events; TCK is never used as a clock.
//               Provides IDCODE, BYPASS and one parallel-in/out USER DR.
// Ports       : clk, rst_n          system clock / async active-low reset
//               tck, tms, tdi       JTAG pins from the host (async to clk)
//               tdo, tdo_oe         JTAG data out and its enable
//               user_dr_in          value captured into USER DR at Capture-DR
//               user_dr_out         USER DR value latched at Update-DR
//               user_update         1-clk pulse when user_dr_out is written
//               tap_state           current TAP state encoding (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_tap_ctrl #(
  parameter int              IR_W        = 5,
  parameter logic [31:0]     IDCODE_VAL  = 32'h1000_0001,
  parameter int              USER_W      = 32,
  parameter logic [IR_W-1:0] IR_IDCODE   = IR_W'(1),
  parameter logic [IR_W-1:0] IR_USER     = IR_W'(8),
  parameter int              SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tck,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic              tdo_oe,
  input  logic [USER_W-1:0] user_dr_in,
  output logic [USER_W-1:0] user_dr_out,
  output logic              user_update,
  output logic [3:0]        tap_state
);

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
    PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
    PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_e;

  // All three pins go through identical chains so tms/tdi stay aligned
  // with the tck edge they belong to.
  logic [SYNC_STAGES-1:0] tck_sync_q, tms_sync_q, tdi_sync_q;
  logic                   tck_prev_q;
  logic                   sync_tck, sync_tms, sync_tdi;
  logic                   tck_rise, tck_fall;

  tap_state_e             state_q, state_d;
  logic [IR_W-1:0]        ir_q, ir_sh_q;
  logic [31:0]            id_sh_q;
  logic [USER_W-1:0]      usr_sh_q, user_dr_out_q;
  logic                   byp_q;
  logic                   tdo_q, tdo_oe_q, user_update_q;
  logic                   sel_idcode, sel_user, dr_lsb;

  assign sync_tck = tck_sync_q[SYNC_STAGES-1];
  assign sync_tms = tms_sync_q[SYNC_STAGES-1];
  assign sync_tdi = tdi_sync_q[SYNC_STAGES-1];
  assign tck_rise = sync_tck & ~tck_prev_q;
  assign tck_fall = ~sync_tck & tck_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tck_sync_q <= '0;
      tms_sync_q <= '0;
      tdi_sync_q <= '0;
      tck_prev_q <= 1'b0;
    end else begin
      tck_sync_q <= {tck_sync_q[SYNC_STAGES-2:0], tck};
      tms_sync_q <= {tms_sync_q[SYNC_STAGES-2:0], tms};
      tdi_sync_q <= {tdi_sync_q[SYNC_STAGES-2:0], tdi};
      tck_prev_q <= sync_tck;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= TLR;
    else        state_q <= state_d;
  end

  // Next state: advances only on a synchronised TCK rise
  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      case (state_q)
        TLR:     state_d = sync_tms ? TLR    : RTI;
        RTI:     state_d = sync_tms ? SEL_DR : RTI;
        SEL_DR:  state_d = sync_tms ? SEL_IR : CAP_DR;
        CAP_DR:  state_d = sync_tms ? EX1_DR : SH_DR;
        SH_DR:   state_d = sync_tms ? EX1_DR : SH_DR;
        EX1_DR:  state_d = sync_tms ? UPD_DR : PAU_DR;
        PAU_DR:  state_d = sync_tms ? EX2_DR : PAU_DR;
        EX2_DR:  state_d = sync_tms ? UPD_DR : SH_DR;
        UPD_DR:  state_d = sync_tms ? SEL_DR : RTI;
        SEL_IR:  state_d = sync_tms ? TLR    : CAP_IR;
        CAP_IR:  state_d = sync_tms ? EX1_IR : SH_IR;
        SH_IR:   state_d = sync_tms ? EX1_IR : SH_IR;
        EX1_IR:  state_d = sync_tms ? UPD_IR : PAU_IR;
        PAU_IR:  state_d = sync_tms ? EX2_IR : PAU_IR;
        EX2_IR:  state_d = sync_tms ? UPD_IR : SH_IR;
        UPD_IR:  state_d = sync_tms ? SEL_DR : RTI;
        default: state_d = TLR;
      endcase
    end
  end

  // Any opcode other than IDCODE/USER falls through to BYPASS
  assign sel_idcode = (ir_q == IR_IDCODE);
  assign sel_user   = (ir_q == IR_USER) && !sel_idcode;

  always_comb begin
    dr_lsb = byp_q;
    if (sel_idcode)    dr_lsb = id_sh_q[0];
    else if (sel_user) dr_lsb = usr_sh_q[0];
  end

  // Register actions, keyed on the state before the transition
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q          <= IR_IDCODE;
      ir_sh_q       <= '0;
      id_sh_q       <= '0;
      usr_sh_q      <= '0;
      byp_q         <= 1'b0;
      user_dr_out_q <= '0;
      user_update_q <= 1'b0;
      tdo_q         <= 1'b0;
      tdo_oe_q      <= 1'b0;
    end else begin
      user_update_q <= 1'b0;
      if (tck_rise) begin
        case (state_q)
          CAP_IR: ir_sh_q <= IR_W'(1);
          SH_IR:  ir_sh_q <= {sync_tdi, ir_sh_q[IR_W-1:1]};
          UPD_IR: ir_q    <= ir_sh_q;
          CAP_DR: begin
            if (sel_idcode)    id_sh_q  <= IDCODE_VAL;
            else if (sel_user) usr_sh_q <= user_dr_in;
            else               byp_q    <= 1'b0;
          end
          SH_DR: begin
            if (sel_idcode)    id_sh_q  <= {sync_tdi, id_sh_q[31:1]};
            else if (sel_user) usr_sh_q <= {sync_tdi, usr_sh_q[USER_W-1:1]};
            else               byp_q    <= sync_tdi;
          end
          UPD_DR: begin
            if (sel_user) begin
              user_dr_out_q <= usr_sh_q;
              user_update_q <= 1'b1;
            end
          end
          default: ;
        endcase
        // Entering Test-Logic-Reset always restores IDCODE
        if (state_d == TLR) ir_q <= IR_IDCODE;
      end
      if (tck_fall) begin
        tdo_oe_q <= (state_q == SH_IR) || (state_q == SH_DR);
        if (state_q == SH_IR)      tdo_q <= ir_sh_q[0];
        else if (state_q == SH_DR) tdo_q <= dr_lsb;
      end
    end
  end

  assign tdo         = tdo_q;
  assign tdo_oe      = tdo_oe_q;
  assign user_dr_out = user_dr_out_q;
  assign user_update = user_update_q;
  assign tap_state   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_jtag_tap_ctrl
// Description : Self-checking bench for jtag_tap_ctrl. A transaction-level
//               TAP model (transition table + shift-register arithmetic) is
//               advanced at the moment each pin edge must take effect, and a
//               compare process checks every DUT output on every clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jtag_tap_ctrl;
  localparam int SYNC = 2;
  localparam logic [3:0] TLR = 4'hF, RTI = 4'hC, SDR = 4'h2, CDR = 4'h6,
                         UDR = 4'h5, SIR = 4'hA, CIR = 4'hE, UIR = 4'hD;

  logic        clk = 1'b0, rst_n = 1'b0, tck = 1'b0, tms = 1'b0, tdi = 1'b0;
  logic [31:0] user_in = '0;
  logic        tdo, tdo_oe, user_update;
  logic [31:0] user_out;
  logic [3:0]  tap_state;

  int errors = 0, checks = 0, upd_cnt = 0;

  always #5 clk = ~clk;

  jtag_tap_ctrl #(
    .IR_W(5), .IDCODE_VAL(32'h1000_0001), .USER_W(32),
    .IR_IDCODE(5'h01), .IR_USER(5'h08), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tck(tck), .tms(tms), .tdi(tdi),
    .tdo(tdo), .tdo_oe(tdo_oe), .user_dr_in(user_in),
    .user_dr_out(user_out), .user_update(user_update), .tap_state(tap_state)
  );

  // ---------------- reference model ----------------
  logic [3:0]  nxt0 [16];
  logic [3:0]  nxt1 [16];
  logic [3:0]  m_state;
  logic [4:0]  m_ir, m_irsh;
  logic [31:0] m_id, m_usr, m_out;
  logic        m_byp, m_tdo, m_oe, m_upd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = TLR; m_ir = 5'h01; m_irsh = '0; m_id = '0; m_usr = '0;
    m_out = '0; m_byp = 1'b0; m_tdo = 1'b0; m_oe = 1'b0; m_upd = 1'b0;
  endtask

  task automatic m_rise(input logic t_ms, input logic t_di);
    case (m_state)
      CIR: m_irsh = 5'b00001;
      SIR: m_irsh = (m_irsh >> 1) | (5'(t_di) << 4);
      UIR: m_ir = m_irsh;
      CDR: begin
        if (m_ir == 5'h01)      m_id  = 32'h1000_0001;
        else if (m_ir == 5'h08) m_usr = user_in;
        else                    m_byp = 1'b0;
      end
      SDR: begin
        if (m_ir == 5'h01)      m_id  = (m_id >> 1)  | (32'(t_di) << 31);
        else if (m_ir == 5'h08) m_usr = (m_usr >> 1) | (32'(t_di) << 31);
        else                    m_byp = t_di;
      end
      UDR: if (m_ir == 5'h08) begin m_out = m_usr; m_upd = 1'b1; end
      default: ;
    endcase
    m_state = t_ms ? nxt1[m_state] : nxt0[m_state];
    if (m_state == TLR) m_ir = 5'h01;
  endtask

  task automatic m_fall();
    if (m_state == SIR) begin
      m_tdo = m_irsh[0]; m_oe = 1'b1;
    end else if (m_state == SDR) begin
      m_tdo = (m_ir == 5'h01) ? m_id[0] : (m_ir == 5'h08) ? m_usr[0] : m_byp;
      m_oe  = 1'b1;
    end else begin
      m_oe = 1'b0;
    end
  endtask

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    chk("tap_state",   {60'b0, tap_state}, {60'b0, m_state});
    chk("tdo",         {63'b0, tdo},       {63'b0, m_tdo});
    chk("tdo_oe",      {63'b0, tdo_oe},    {63'b0, m_oe});
    chk("user_dr_out", {32'b0, user_out},  {32'b0, m_out});
    chk("user_update", {63'b0, user_update}, {63'b0, m_upd});
  end

  always @(negedge clk) if (user_update === 1'b1) upd_cnt++;

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus helpers ----------------
  // One TCK period; the model takes each edge exactly SYNC+1 clocks after the pin.
  task automatic tck_cycle(input logic t_ms, input logic t_di);
    @(negedge clk); tck = 1'b1; tms = t_ms; tdi = t_di;
    repeat (SYNC + 1) @(posedge clk);
    m_rise(t_ms, t_di);
    @(posedge clk); m_upd = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk); tck = 1'b0;
    repeat (SYNC + 1) @(posedge clk);
    m_fall();
    repeat (4) @(negedge clk);
  endtask

  task automatic tms_seq(input logic [15:0] bits, input int len);
    for (int i = 0; i < len; i++) tck_cycle(bits[i], 1'b0);
  endtask

  task automatic shift_bits(input int n, input logic [63:0] din, output logic [63:0] dout);
    dout = '0;
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      tck_cycle(i == n - 1, din[i]);
    end
  endtask

  task automatic load_ir(input logic [4:0] v, output logic [4:0] cap);
    logic [63:0] d;
    tms_seq(16'b0011, 4);
    shift_bits(5, {59'b0, v}, d);
    cap = d[4:0];
    tms_seq(16'b01, 2);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst_n = 1'b0; m_reset();
    repeat (3) @(negedge clk);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
  endtask

  logic [3:0]  tgt   [16];
  logic [15:0] pbits [16];
  int          plen  [16];

  initial begin
    logic [63:0] d, d1, d2;
    logic [4:0]  cap;
    int          uc;

    nxt0[4'hF] = 4'hC; nxt1[4'hF] = 4'hF;  nxt0[4'hC] = 4'hC; nxt1[4'hC] = 4'h7;
    nxt0[4'h7] = 4'h6; nxt1[4'h7] = 4'h4;  nxt0[4'h6] = 4'h2; nxt1[4'h6] = 4'h1;
    nxt0[4'h2] = 4'h2; nxt1[4'h2] = 4'h1;  nxt0[4'h1] = 4'h3; nxt1[4'h1] = 4'h5;
    nxt0[4'h3] = 4'h3; nxt1[4'h3] = 4'h0;  nxt0[4'h0] = 4'h2; nxt1[4'h0] = 4'h5;
    nxt0[4'h5] = 4'hC; nxt1[4'h5] = 4'h7;  nxt0[4'h4] = 4'hE; nxt1[4'h4] = 4'hF;
    nxt0[4'hE] = 4'hA; nxt1[4'hE] = 4'h9;  nxt0[4'hA] = 4'hA; nxt1[4'hA] = 4'h9;
    nxt0[4'h9] = 4'hB; nxt1[4'h9] = 4'hD;  nxt0[4'hB] = 4'hB; nxt1[4'hB] = 4'h8;
    nxt0[4'h8] = 4'hA; nxt1[4'h8] = 4'hD;  nxt0[4'hD] = 4'hC; nxt1[4'hD] = 4'h7;

    // Paths from Run-Test/Idle to each of the 16 states (bit0 applied first)
    tgt[0]  = 4'hC; plen[0]  = 0; pbits[0]  = 16'b0;
    tgt[1]  = 4'h7; plen[1]  = 1; pbits[1]  = 16'b1;
    tgt[2]  = 4'h6; plen[2]  = 2; pbits[2]  = 16'b01;
    tgt[3]  = 4'h2; plen[3]  = 3; pbits[3]  = 16'b001;
    tgt[4]  = 4'h1; plen[4]  = 3; pbits[4]  = 16'b101;
    tgt[5]  = 4'h3; plen[5]  = 4; pbits[5]  = 16'b0101;
    tgt[6]  = 4'h0; plen[6]  = 5; pbits[6]  = 16'b10101;
    tgt[7]  = 4'h5; plen[7]  = 4; pbits[7]  = 16'b1101;
    tgt[8]  = 4'h4; plen[8]  = 2; pbits[8]  = 16'b11;
    tgt[9]  = 4'hE; plen[9]  = 3; pbits[9]  = 16'b011;
    tgt[10] = 4'hA; plen[10] = 4; pbits[10] = 16'b0011;
    tgt[11] = 4'h9; plen[11] = 4; pbits[11] = 16'b1011;
    tgt[12] = 4'hB; plen[12] = 5; pbits[12] = 16'b01011;
    tgt[13] = 4'h8; plen[13] = 6; pbits[13] = 16'b101011;
    tgt[14] = 4'hD; plen[14] = 5; pbits[14] = 16'b11011;
    tgt[15] = 4'hF; plen[15] = 3; pbits[15] = 16'b111;

    m_reset();
    repeat (4) @(negedge clk);
    chk("reset_state",  {60'b0, tap_state}, 64'hF);
    chk("reset_tdo_oe", {63'b0, tdo_oe},    64'h0);
    chk("reset_uout",   {32'b0, user_out},  64'h0);
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);

    // IDCODE scan after 5 tms=1 rises
    tms_seq(16'h1F, 5);
    chk("tlr_after_5", {60'b0, tap_state}, 64'hF);
    tms_seq(16'b0010, 4);
    chk("oe_in_shift", {63'b0, tdo_oe}, 64'h1);
    shift_bits(32, {32'b0, $urandom}, d);
    chk("idcode_stream", d, 64'h1000_0001);
    chk("oe_after_shift", {63'b0, tdo_oe}, 64'h0);
    tms_seq(16'b01, 2);

    // BYPASS via all-ones opcode
    load_ir(5'h1F, cap);
    chk("capture_ir", {59'b0, cap}, 64'h01);
    tms_seq(16'b001, 3);
    shift_bits(9, {55'b0, 1'b0, 8'hB2}, d);
    chk("bypass_stream", {55'b0, d[8:0]}, {55'b0, 8'hB2, 1'b0});
    tms_seq(16'b01, 2);

    // USER write
    load_ir(5'h08, cap);
    tms_seq(16'b001, 3);
    shift_bits(32, 64'hA5A5_5A5A, d);
    uc = upd_cnt;
    tms_seq(16'b01, 2);
    chk("user_out_write", {32'b0, user_out}, 64'hA5A5_5A5A);
    chk("user_pulse_cnt", 64'(upd_cnt - uc), 64'h1);

    // USER read with a Pause-DR in the middle
    user_in = 32'hDEAD_BEEF;
    tms_seq(16'b001, 3);
    shift_bits(16, {48'b0, 16'($urandom)}, d1);
    tms_seq(16'b0100, 4);
    shift_bits(16, {48'b0, 16'($urandom)}, d2);
    chk("user_read_pause", {32'b0, d2[15:0], d1[15:0]}, 64'hDEAD_BEEF);
    tms_seq(16'b01, 2);

    // Five tms=1 rises from every state reach TLR and restore IDCODE
    user_in = 32'hDEAD_BEEE;
    for (int k = 0; k < 16; k++) begin
      load_ir(5'h08, cap);
      tms_seq(pbits[k], plen[k]);
      chk("model_path", {60'b0, m_state}, {60'b0, tgt[k]});
      chk("dut_path",   {60'b0, tap_state}, {60'b0, tgt[k]});
      tms_seq(16'h1F, 5);
      chk("force_tlr", {60'b0, tap_state}, 64'hF);
      tms_seq(16'b0010, 4);
      chk("ir_idcode_bit0", {63'b0, tdo}, 64'h1);
      tms_seq(16'b011, 3);
    end

    // Reset in the middle of a USER shift
    load_ir(5'h08, cap);
    tms_seq(16'b001, 3);
    for (int i = 0; i < 10; i++) tck_cycle(1'b0, 1'($urandom));
    uc = upd_cnt;
    do_reset();
    chk("midrst_state", {60'b0, tap_state}, 64'hF);
    chk("midrst_oe",    {63'b0, tdo_oe},    64'h0);
    chk("midrst_uout",  {32'b0, user_out},  64'h0);
    chk("midrst_nopulse", 64'(upd_cnt - uc), 64'h0);
    tms_seq(16'b0010, 4);
    shift_bits(32, {32'b0, $urandom}, d);
    chk("idcode_after_rst", d, 64'h1000_0001);
    tms_seq(16'b01, 2);

    // Random TMS/TDI traffic with occasional resets and USER value changes
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(63) == 0) do_reset();
      if ($urandom_range(15) == 0) user_in = $urandom;
      tck_cycle(1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
